tiny_tpu: RTL and testbench

// - Top-level TPU: weight-stationary NxN systolic array of signed MAC PEs, controller FSM, result registers.
// - Weight matrix W and input matrix X are hard-coded constants inside the block; no host data path yet.
// - After reset release it computes C = X*W once, latches C and raises done.
// - Testbench top; the outputs are observation ports only.

---
 rtl/tiny_tpu.sv | 176 +++++++++++++++++
 tb/tb_tiny_tpu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_tpu.sv
`timescale 1ns/1ps
// tiny_tpu: weight-stationary NxN systolic array of signed MAC PEs with a
// controller FSM. W and X are fixed parameters. After reset release the block
// loads W, streams X through the array once, latches C = X*W and holds done.
module tiny_tpu #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  // Element [r][c] lives at bits [(r*N+c)*DATA_W +: DATA_W].
  parameter logic [N*N*DATA_W-1:0] W_FLAT = 32'h0403_0201,
  parameter logic [N*N*DATA_W-1:0] X_FLAT = 32'h0807_0605
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  output logic                 done,
  output logic [N*N*ACC_W-1:0] result_flat
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_e;

  localparam int               CNT_W     = $clog2(3 * N);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(3 * N - 3);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Weight per PE, activation passed to the right neighbour (last column has
  // no neighbour), partial sum passed down (bottom row feeds the capture logic).
  logic signed [DATA_W-1:0] w_q    [N][N];
  logic signed [DATA_W-1:0] act_q  [N][N-1];
  logic signed [ACC_W-1:0]  psum_q [N-1][N];

  logic signed [DATA_W-1:0] feed   [N];
  logic signed [DATA_W-1:0] a_in   [N][N];
  logic signed [ACC_W-1:0]  psum_d [N][N];
  logic signed [ACC_W-1:0]  res_q  [N][N];

  // Controller state and cycle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE(1) -> LOAD(N) -> COMPUTE(3N-2) -> DONE (sticky)
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == COMP_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Skewed left-edge feed: row i sees X[t-i][i] during COMPUTE, else 0
  always_comb begin
    int d;
    d = 0;
    for (int i = 0; i < N; i++) begin
      feed[i] = '0;
      d = int'(cnt_q) - i;
      if (state_q == S_COMPUTE && d >= 0 && d < N)
        feed[i] = X_FLAT[(d * N + i) * DATA_W +: DATA_W];
    end
  end

  // MAC datapath for each PE: psum_out = psum_in + a * w, wrapping at ACC_W
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [ACC_W-1:0] p_in;
      logic signed [ACC_W-1:0] a_ext;
      logic signed [ACC_W-1:0] w_ext;

      if (j == 0) begin : g_left
        assign a_in[i][j] = feed[i];
      end else begin : g_inner
        assign a_in[i][j] = act_q[i][j-1];
      end

      if (i == 0) begin : g_top
        assign p_in = '0;
      end else begin : g_below
        assign p_in = psum_q[i-1][j];
      end

      assign a_ext        = ACC_W'(a_in[i][j]);
      assign w_ext        = ACC_W'(w_q[i][j]);
      assign psum_d[i][j] = p_in + a_ext * w_ext;
    end
  end

  // PE registers: weight shift chain during LOAD, activations right, psums down
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these arrays are reset because a restart must not see stale
      // weights or in-flight partial sums from an aborted run.
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w_q[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++)
          act_q[i][j] <= '0;
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++)
          psum_q[i][j] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++)
          act_q[i][j] <= a_in[i][j];
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++)
          psum_q[i][j] <= psum_d[i][j];
      if (state_q == S_LOAD) begin
        // Bottom weight row goes in first so row i holds W[i] after N shifts.
        for (int j = 0; j < N; j++)
          w_q[0][j] <= W_FLAT[((N - 1 - int'(cnt_q)) * N + j) * DATA_W +: DATA_W];
        for (int i = 1; i < N; i++)
          for (int j = 0; j < N; j++)
            w_q[i][j] <= w_q[i-1][j];
      end
    end
  end

  // Capture C[r][j] as it leaves the bottom of column j at t = r + j + N - 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          res_q[r][j] <= '0;
    end else if (state_q == S_COMPUTE) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          if (int'(cnt_q) == r + j + N - 1)
            res_q[r][j] <= psum_d[N-1][j];
    end
  end

  // Status flags and flattened result view
  always_comb begin
    busy        = (state_q == S_LOAD) || (state_q == S_COMPUTE);
    done        = (state_q == S_DONE);
    result_flat = '0;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        result_flat[(r * N + j) * ACC_W +: ACC_W] = res_q[r][j];
  end

endmodule

// File: tb/tb_tiny_tpu.sv
`timescale 1ns/1ps
// Bench for tiny_tpu: three instances (default constants, signed/overflow
// constants, N=3 identity). Expected C and latency are pushed per run into a
// queue per instance; a negedge monitor pops on each done rise and compares.
module tb_tiny_tpu;

  localparam int RW = 9 * 16;

  typedef struct {
    int             lat;
    logic [RW-1:0]  res;
  } exp_t;

  logic clk;
  logic reset;

  logic          busy_a, done_a;
  logic [63:0]   res_a;
  logic          busy_s, done_s;
  logic [63:0]   res_s;
  logic          busy_n, done_n;
  logic [143:0]  res_n;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [RW-1:0] ref_v [3];
  int            lat_v [3];
  logic          done_v [3];
  logic          busy_v [3];
  logic [RW-1:0] res_v [3];
  logic          have_cur [3];
  logic          done_prev [3];
  exp_t          cur [3];

  int wa[3][3] = '{'{1, 2, 0}, '{3, 4, 0}, '{0, 0, 0}};
  int xa[3][3] = '{'{5, 6, 0}, '{7, 8, 0}, '{0, 0, 0}};
  int ws[3][3] = '{'{-1, 127, 0}, '{2, -128, 0}, '{0, 0, 0}};
  int xs[3][3] = '{'{127, -128, 0}, '{1, 1, 0}, '{0, 0, 0}};
  int wn[3][3] = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
  int xn[3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};

  tiny_tpu dut_a (
    .clk(clk), .reset(reset), .busy(busy_a), .done(done_a), .result_flat(res_a)
  );

  tiny_tpu #(
    .N(2), .DATA_W(8), .ACC_W(16),
    .W_FLAT({8'h80, 8'h02, 8'h7f, 8'hff}),
    .X_FLAT({8'h01, 8'h01, 8'h80, 8'h7f})
  ) dut_s (
    .clk(clk), .reset(reset), .busy(busy_s), .done(done_s), .result_flat(res_s)
  );

  tiny_tpu #(
    .N(3), .DATA_W(8), .ACC_W(16),
    .W_FLAT({8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1}),
    .X_FLAT({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1})
  ) dut_n (
    .clk(clk), .reset(reset), .busy(busy_n), .done(done_n), .result_flat(res_n)
  );

  assign done_v[0] = done_a;
  assign done_v[1] = done_s;
  assign done_v[2] = done_n;
  assign busy_v[0] = busy_a;
  assign busy_v[1] = busy_s;
  assign busy_v[2] = busy_n;
  assign res_v[0]  = {80'b0, res_a};
  assign res_v[1]  = {80'b0, res_s};
  assign res_v[2]  = res_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release: edge 1 is the first rising edge after release.
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain matrix product C = X*W, each element wrapped to 16 bits.
  function automatic logic [RW-1:0] ref_mm(input int n, input int w[3][3], input int x[3][3]);
    logic [RW-1:0] v;
    int s;
    v = '0;
    for (int r = 0; r < n; r++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += x[r][k] * w[k][j];
        v[(r * n + j) * 16 +: 16] = 16'(s);
      end
    return v;
  endfunction

  task automatic push_all();
    exp_t e;
    e.lat = lat_v[0]; e.res = ref_v[0]; q0.push_back(e);
    e.lat = lat_v[1]; e.res = ref_v[1]; q1.push_back(e);
    e.lat = lat_v[2]; e.res = ref_v[2]; q2.push_back(e);
  endtask

  task automatic flush_all();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  function automatic bit pop_exp(input int id, output exp_t e);
    bit ok;
    ok = 1'b0;
    e.lat = 0;
    e.res = '0;
    case (id)
      0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  // Monitor: flag timing against edge count, pop and compare on each done rise,
  // then require the result to stay frozen while done is held.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    for (int id = 0; id < 3; id++) begin
      check($sformatf("busy[%0d]@edge%0d", id, edge_cnt), busy_v[id],
            (edge_cnt >= 1) && (edge_cnt < lat_v[id]));
      check($sformatf("done[%0d]@edge%0d", id, edge_cnt), done_v[id],
            edge_cnt >= lat_v[id]);
      if (!reset) begin
        have_cur[id]  = 1'b0;
        done_prev[id] = 1'b0;
      end else begin
        if (done_v[id] && !done_prev[id]) begin
          ok = pop_exp(id, e);
          check($sformatf("sb_pending[%0d]", id), ok, 1'b1);
          if (ok) begin
            check($sformatf("latency[%0d]", id), edge_cnt, e.lat);
            cur[id]      = e;
            have_cur[id] = 1'b1;
          end
        end
        if (done_v[id] && have_cur[id])
          check($sformatf("result[%0d]", id), res_v[id], cur[id].res);
        done_prev[id] = done_v[id];
      end
    end
  end

  task automatic check_cleared(input string tag);
    for (int id = 0; id < 3; id++) begin
      check($sformatf("%s_busy[%0d]", tag, id), busy_v[id], 1'b0);
      check($sformatf("%s_done[%0d]", tag, id), done_v[id], 1'b0);
      check($sformatf("%s_result[%0d]", tag, id), res_v[id], '0);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2;
    reset = 1'b1;
    push_all();
  endtask

  task automatic wait_all_done(input int budget);
    int i;
    i = 0;
    while (!(done_a && done_s && done_n) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("done_timeout", done_a && done_s && done_n, 1'b1);
  endtask

  task automatic restart();
    reset = 1'b0;
    flush_all();
    repeat ($urandom_range(1, 3)) @(posedge clk);
    release_rst();
  endtask

  // Assert reset shortly after the given edge, away from any clock edge.
  task automatic abort_at(input int k);
    do begin
      @(posedge clk);
      #1;
    end while (edge_cnt < k);
    #($urandom_range(0, 2));
    reset = 1'b0;
    flush_all();
    #1;
    check_cleared($sformatf("abort%0d", k));
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  initial begin
    ref_v[0] = ref_mm(2, wa, xa);
    ref_v[1] = ref_mm(2, ws, xs);
    ref_v[2] = ref_mm(3, wn, xn);
    lat_v[0] = 4 * 2 - 1;
    lat_v[1] = 4 * 2 - 1;
    lat_v[2] = 4 * 3 - 1;
    for (int id = 0; id < 3; id++) begin
      have_cur[id]  = 1'b0;
      done_prev[id] = 1'b0;
    end

    reset = 1'b0;
    #1;
    check_cleared("por");
    #19;
    reset = 1'b1;
    push_all();
    wait_all_done(60);
    repeat (50) @(posedge clk);

    restart();
    abort_at(4);
    release_rst();
    wait_all_done(60);
    repeat ($urandom_range(5, 20)) @(posedge clk);

    for (int it = 0; it < 4; it++) begin
      restart();
      abort_at($urandom_range(1, 10));
      release_rst();
      wait_all_done(60);
      repeat ($urandom_range(5, 20)) @(posedge clk);
    end

    @(negedge clk);
    #1;
    check("sb_drained[0]", q0.size(), 0);
    check("sb_drained[1]", q1.size(), 0);
    check("sb_drained[2]", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
